mod_reducer: RTL and testbench
==============================

MOD_REDUCER -- requirements
Module: mod_reducer

Interface
REQ-001 SHALL have parameter WIDTH, default 6: operand and modulus width; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: product/modulus pair offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a pair.
REQ-006 SHALL have port product, input, 2*WIDTH bits: multiplier output to reduce.
REQ-007 SHALL have port modulus, input, WIDTH bits: RSA modulus N.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port remainder, output, WIDTH bits: product mod modulus.
REQ-011 SHALL have port div_zero, output, 1 bit: the captured modulus was 0.

Function
REQ-012 SHALL implement states IDLE, REDUCE and DONE.
REQ-013 SHALL drive in_ready high only in IDLE; out_valid SHALL be high only in DONE.
REQ-014 SHALL, on an edge in IDLE with in_valid=1, capture product and modulus, clear the internal (WIDTH+1)-bit partial remainder and the bit counter, and enter REDUCE.
REQ-015 SHALL, in each REDUCE cycle, shift the next product bit (MSB first) into the partial remainder, then subtract modulus if the partial remainder is greater than or equal to modulus.
REQ-016 SHALL process exactly 2*WIDTH bits, then enter DONE; out_valid asserts 2*WIDTH cycles after the acceptance edge.
REQ-017 SHALL, if the captured modulus is 0, enter DONE on the cycle after acceptance with remainder=0 and div_zero=1.
REQ-018 SHALL, for a nonzero modulus, set div_zero=0 and present remainder equal to product mod modulus in the low WIDTH bits.
REQ-019 SHALL hold remainder, div_zero and out_valid stable in DONE while out_ready=0.
REQ-020 SHALL, on an edge in DONE with out_ready=1, return to IDLE; the next pair is accepted one cycle later, with no same-cycle turnaround.
REQ-021 SHALL ignore in_valid outside IDLE; product and modulus SHALL NOT be re-sampled during REDUCE.
REQ-022 SHALL keep remainder at its last value while in IDLE and REDUCE.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, force IDLE and clear out_valid, remainder, div_zero, the partial remainder and the bit counter. in_ready therefore reads 1.
REQ-024 SHALL give reset priority over all handshakes, aborting any REDUCE or DONE with no output produced.

Configuration
REQ-025 SHALL use macro MOD_REDUCER_BYPASS_LT_EN. When it is defined, a pair accepted with a nonzero modulus and product < modulus (modulus zero-extended) SHALL enter DONE on the next cycle with remainder=product[WIDTH-1:0].
REQ-026 SHALL, when MOD_REDUCER_BYPASS_LT_EN is undefined, take the full 2*WIDTH-cycle REDUCE path for every nonzero modulus; results SHALL be identical in both builds and only latency differs.

Verification (WIDTH=6)
REQ-027 SHALL cover: product=1225 (35*35), modulus=47, out_ready=1 -> remainder=3, div_zero=0, out_valid 12 cycles after acceptance.
REQ-028 SHALL cover: product=3969, modulus=61 -> remainder=4; hold out_ready=0 for 5 cycles -> out_valid, remainder and div_zero stay stable, in_ready stays 0.
REQ-029 SHALL cover: product=20, modulus=47 -> remainder=20, latency 1 cycle with MOD_REDUCER_BYPASS_LT_EN defined and 12 cycles without it.
REQ-030 SHALL cover: product=100, modulus=0 -> div_zero=1, remainder=0, out_valid one cycle after acceptance.
REQ-031 SHALL cover: reset asserted on the 5th REDUCE cycle -> next cycle IDLE, in_ready=1, out_valid=0, remainder=0; a new pair of 1225 mod 47 then returns 3.
REQ-032 SHALL cover: back-to-back pairs with in_valid held high and out_ready=1 -> the second pair is accepted exactly one cycle after the first result's handshake.

Source files
------------

// File: rtl/mod_reducer.sv
// -----------------------------------------------------------------------------
// mod_reducer
//
// Purpose:
//   Reduces a 2*WIDTH-bit product modulo a WIDTH-bit modulus by restoring
//   long division. The product is consumed MSB first, one bit per clock.
//   Each accepted pair produces exactly one result through a valid/ready
//   handshake.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   product/modulus pair offered
//   in_ready   out  block is idle and can accept a pair
//   product    in   [2*WIDTH-1:0] value to reduce
//   modulus    in   [WIDTH-1:0]   modulus N
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   remainder  out  [WIDTH-1:0]   product mod modulus (0 when modulus is 0)
//   div_zero   out  the captured modulus was 0
//
// Configuration:
//   MOD_REDUCER_BYPASS_LT_EN - when defined, a pair whose product is already
//   below a nonzero modulus finishes one cycle after acceptance instead of
//   running the full reduction. Results are identical in both builds.
// -----------------------------------------------------------------------------
module mod_reducer #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   product,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [PW-1:0]      r_prod;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH:0]     r_part;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dz;

    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH:0]     w_step;
    logic               w_mod_zero;
    logic               w_bypass;
    logic               w_last;

    // Reduction step: shift in the next product bit, subtract N when it fits.
    always_comb begin
        w_shift    = {r_part[WIDTH-1:0], r_prod[PW-1]};
        // The partial stays below N, so its top bit is normally 0; if it were
        // ever set the shifted value would exceed N and must be reduced.
        w_ge       = r_part[WIDTH] | (w_shift >= {1'b0, r_mod});
        if (w_ge) begin
            w_step = w_shift - {1'b0, r_mod};
        end else begin
            w_step = w_shift;
        end
        w_mod_zero = (r_mod == {WIDTH{1'b0}});
        w_last     = (r_cnt == LAST_CNT);
`ifdef MOD_REDUCER_BYPASS_LT_EN
        // Only valid on the first REDUCE cycle, before r_prod starts shifting.
        w_bypass   = (r_cnt == {CW{1'b0}}) && (r_prod < {{WIDTH{1'b0}}, r_mod});
`else
        w_bypass   = 1'b0;
`endif
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = REDUCE;
                end else begin
                    w_next = IDLE;
                end
            end
            REDUCE: begin
                if (w_mod_zero || w_bypass || w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = REDUCE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
        end
    end

    // Datapath: capture on acceptance, iterate in REDUCE, load result on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= {PW{1'b0}};
            r_mod  <= {WIDTH{1'b0}};
            r_part <= {(WIDTH+1){1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_rem  <= {WIDTH{1'b0}};
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_prod <= product;
                        r_mod  <= modulus;
                        r_part <= {(WIDTH+1){1'b0}};
                        r_cnt  <= {CW{1'b0}};
                    end
                end
                REDUCE: begin
                    if (w_mod_zero) begin
                        r_rem <= {WIDTH{1'b0}};
                        r_dz  <= 1'b1;
                    end else if (w_bypass) begin
                        r_rem <= r_prod[WIDTH-1:0];
                        r_dz  <= 1'b0;
                    end else begin
                        r_part <= w_step;
                        r_prod <= {r_prod[PW-2:0], 1'b0};
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_rem <= w_step[WIDTH-1:0];
                            r_dz  <= 1'b0;
                        end
                    end
                end
                default: begin
                    // DONE holds everything until the handshake.
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_mod_reducer.sv
// -----------------------------------------------------------------------------
// tb_mod_reducer
//
// Purpose:
//   Directed self-checking bench for mod_reducer (WIDTH=6). Expected results
//   and latencies are computed by the bench at stimulus time, pushed to a
//   scoreboard queue and compared when the DUT raises out_valid.
//   Honours MOD_REDUCER_BYPASS_LT_EN when computing expected latency.
// -----------------------------------------------------------------------------
module tb_mod_reducer;

    localparam int W   = 6;
    localparam int MAX_WAIT = 40;

    typedef struct {
        logic [W-1:0] rem;
        logic         dz;
        int           lat;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   product;
    logic [W-1:0]     modulus;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     remainder;
    logic             div_zero;

    int               n_checks;
    int               n_errors;
    exp_t             sb_q[$];
    logic [W-1:0]     last_rem;
    logic             last_dz;

    mod_reducer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .modulus   (modulus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] p, input logic [W-1:0] m);
        exp_t e;
        if (m == 6'd0) begin
            e.rem = 6'd0;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.rem = W'(int'(p) % int'(m));
            e.dz  = 1'b0;
            e.lat = 2 * W;
`ifdef MOD_REDUCER_BYPASS_LT_EN
            if (int'(p) < int'(m)) e.lat = 1;
`endif
        end
        return e;
    endfunction

    // Offer a pair while idle, take the acceptance edge and record expectation.
    task automatic send(input logic [2*W-1:0] p, input logic [W-1:0] m, input logic keep_valid);
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        product  = p;
        modulus  = m;
        in_valid = 1'b1;
        step();
        sb_q.push_back(model(p, m));
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; check hold-while-busy, latency and result.
    task automatic wait_result();
        int   lat;
        exp_t e;
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
            check("rem_held_busy", {26'd0, remainder}, {26'd0, last_rem});
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            step();
            lat++;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("latency", lat, e.lat);
            check("remainder", {26'd0, remainder}, {26'd0, e.rem});
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            last_rem = e.rem;
            last_dz  = e.dz;
        end
    endtask

    // Hold the result for some cycles with out_ready low, then hand it off.
    task automatic collect(input int hold);
        wait_result();
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_remainder", {26'd0, remainder}, {26'd0, last_rem});
            check("hold_div_zero", {31'd0, div_zero}, {31'd0, last_dz});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_rem  = 6'd0;
        last_dz   = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        product   = 12'd0;
        modulus   = 6'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_remainder", {26'd0, remainder}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);

        // 35*35 mod 47 with the consumer ready.
        send(12'd1225, 6'd47, 1'b0);
        collect(0);

        // 63*63 mod 61 with 5 cycles of backpressure.
        send(12'd3969, 6'd61, 1'b0);
        collect(5);

        // Product already below modulus (bypass-dependent latency).
        send(12'd20, 6'd47, 1'b0);
        collect(0);

        // Reset on the 5th REDUCE cycle aborts the reduction.
        send(12'd1225, 6'd47, 1'b0);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_q.delete();
        last_rem = 6'd0;
        last_dz  = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_remainder", {26'd0, remainder}, 32'd0);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        send(12'd1225, 6'd47, 1'b0);
        collect(0);

        // Zero modulus.
        send(12'd100, 6'd0, 1'b0);
        collect(2);

        // Boundary operands.
        send(12'd4095, 6'd63, 1'b0);  collect(0);
        send(12'd4095, 6'd1,  1'b0);  collect(0);
        send(12'd62,   6'd63, 1'b0);  collect(0);
        send(12'd63,   6'd63, 1'b0);  collect(0);
        send(12'd2000, 6'd37, 1'b0);  collect(1);
        send(12'd4094, 6'd62, 1'b0);  collect(0);

        // Back-to-back with in_valid held high; inputs change during REDUCE
        // and must be ignored until the block is idle again.
        out_ready = 1'b1;
        send(12'd1225, 6'd47, 1'b1);
        product = 12'd3969;
        modulus = 6'd61;
        wait_result();
        step();
        check("b2b_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_hs_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(model(12'd3969, 6'd61));
        step();
        in_valid = 1'b0;
        check("b2b_accept_in_ready", {31'd0, in_ready}, 32'd0);
        wait_result();
        step();
        out_ready = 1'b0;
        check("b2b_final_out_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_final_in_ready", {31'd0, in_ready}, 32'd1);

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
